// File: rtl/datapath_param.sv
// Parametrised shared-bus datapath: register file, sequential ALU with iterative shifter, RAM behind MAR.
// Define DATAPATH_FLAGS_EN to add the o_aluFlags {carry, zero} output.
module datapath_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_COUNT      = 4,
    parameter int RAM_ADDR_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_busOverrideEn,
    input  logic [DATA_WIDTH-1:0]        i_busOverride,
    input  logic                         i_ctrlRegWr,
    input  logic [$clog2(REG_COUNT)-1:0] i_ctrlRegWrSel,
    input  logic                         i_ctrlRegBusEn,
    input  logic [$clog2(REG_COUNT)-1:0] i_ctrlRegBusSel,
    input  logic [$clog2(REG_COUNT)-1:0] i_ctrlAluASel,
    input  logic                         i_ctrlAluBWr,
    input  logic [1:0]                   i_ctrlAluOp,
    input  logic                         i_ctrlAluShiftLeft,
    input  logic                         i_ctrlAluStart,
    input  logic                         i_ctrlAluOE,
    input  logic                         i_ctrlRamAddressEn,
    input  logic                         i_ctrlRamWriteEn,
    input  logic                         i_ctrlRamOE,
    output logic [DATA_WIDTH-1:0]        o_bus,
    output logic                         o_aluBusy,
    output logic                         o_aluDone,
`ifdef DATAPATH_FLAGS_EN
    output logic [1:0]                   o_aluFlags,
`endif
    output logic                         o_busConflict
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DATA_WIDTH-1:0]     r_regs [REG_COUNT];
    logic [DATA_WIDTH-1:0]     r_mem [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] r_mar;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [DATA_WIDTH-1:0]     r_pendVal;
    logic                      r_pend;
    logic                      r_done;
    logic [DATA_WIDTH-1:0]     r_work;
    logic [CW-1:0]             r_cnt;
    logic                      r_shl;
    logic                      r_conflict;
    logic [DATA_WIDTH-1:0]     w_bus;
    logic [DATA_WIDTH-1:0]     w_a;
    logic [DATA_WIDTH-1:0]     w_aluRes;
    logic [DATA_WIDTH-1:0]     w_shifted;
    logic [CW-1:0]             w_cnt;
    logic [2:0]                w_nsrc;
    logic                      w_accept;
    logic                      w_finish;
    logic                      w_isShift;

    always_comb begin
        w_bus = '0;
        if (i_busOverrideEn)     w_bus = i_busOverride;
        else if (i_ctrlRamOE)    w_bus = r_mem[r_mar];
        else if (i_ctrlAluOE)    w_bus = r_result;
        else if (i_ctrlRegBusEn) w_bus = r_regs[i_ctrlRegBusSel];
    end

    assign w_nsrc = {2'b00, i_busOverrideEn} + {2'b00, i_ctrlRamOE}
                  + {2'b00, i_ctrlAluOE} + {2'b00, i_ctrlRegBusEn};

    assign w_a       = r_regs[i_ctrlAluASel];
    assign w_cnt     = (r_b >= DATA_WIDTH'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : CW'(r_b);
    assign w_isShift = (i_ctrlAluOp == 2'b11);
    assign w_shifted = r_shl ? {r_work[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, r_work[DATA_WIDTH-1:1]};

    // Zero-count shifts fall through to the one-edge pending path like add/sub/and.
    always_comb begin
        unique case (i_ctrlAluOp)
            2'b00:   w_aluRes = w_a + r_b;
            2'b01:   w_aluRes = w_a - r_b;
            2'b10:   w_aluRes = w_a & r_b;
            default: w_aluRes = w_a;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_ctrlAluStart) begin
                    w_accept = 1'b1;
                    if (w_isShift && w_cnt != '0) w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

`ifdef DATAPATH_FLAGS_EN
    logic [DATA_WIDTH:0] w_sumX;
    logic [DATA_WIDTH:0] w_diffX;
    logic                w_carry;
    logic                w_outBit;
    logic                r_pendCarry;
    logic [1:0]          r_flags;

    assign w_sumX   = {1'b0, w_a} + {1'b0, r_b};
    assign w_diffX  = {1'b0, w_a} - {1'b0, r_b};
    assign w_outBit = r_shl ? r_work[DATA_WIDTH-1] : r_work[0];

    always_comb begin
        unique case (i_ctrlAluOp)
            2'b00:   w_carry = w_sumX[DATA_WIDTH];
            2'b01:   w_carry = w_diffX[DATA_WIDTH];
            default: w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_flags     <= 2'b00;
            r_pendCarry <= 1'b0;
        end else begin
            if (w_accept) r_pendCarry <= w_carry;
            if (r_pend)   r_flags <= {r_pendCarry, r_pendVal == '0};
            if (w_finish) r_flags <= {w_outBit, w_shifted == '0};
        end
    end

    assign o_aluFlags = r_flags;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result  <= '0;
            r_pendVal <= '0;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_shl     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pend <= 1'b0;
            if (r_pend) begin
                r_result <= r_pendVal;
                r_done   <= 1'b1;
            end
            if (w_finish) begin
                r_result <= w_shifted;
                r_done   <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - CW'(1);
            end
            if (w_accept) begin
                if (w_isShift && w_cnt != '0) begin
                    r_work <= w_a;
                    r_cnt  <= w_cnt;
                    r_shl  <= i_ctrlAluShiftLeft;
                end else begin
                    r_pend    <= 1'b1;
                    r_pendVal <= w_aluRes;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
            r_b        <= '0;
            r_mar      <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (i_ctrlRegWr)        r_regs[i_ctrlRegWrSel] <= w_bus;
            if (i_ctrlAluBWr)       r_b <= w_bus;
            if (i_ctrlRamAddressEn) r_mar <= w_bus[RAM_ADDR_WIDTH-1:0];
            if (w_nsrc >= 3'd2 || (i_ctrlRamWriteEn && i_ctrlRamOE))
                r_conflict <= 1'b1;
        end
    end

    // RAM is not reset; a write while RAM drives the bus is dropped.
    always_ff @(posedge i_clk) begin
        if (i_ctrlRamWriteEn && !i_ctrlRamOE) r_mem[r_mar] <= w_bus;
    end

    assign o_bus         = w_bus;
    assign o_aluBusy     = (r_state == SHIFT);
    assign o_aluDone     = r_done;
    assign o_busConflict = r_conflict;

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param with an ALU result scoreboard queue.
module tb_datapath_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       ovEn;
    logic [7:0] ov;
    logic       regWr;
    logic [1:0] regWrSel;
    logic       regBusEn;
    logic [1:0] regBusSel;
    logic [1:0] aSel;
    logic       bWr;
    logic [1:0] op;
    logic       shl;
    logic       start;
    logic       aluOE;
    logic       marEn;
    logic       ramWe;
    logic       ramOE;
    logic [7:0] bus;
    logic       busy;
    logic       done;
    logic       conflict;
`ifdef DATAPATH_FLAGS_EN
    logic [1:0] flags;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [7:0] q[$];

    datapath_param #(.DATA_WIDTH(8), .REG_COUNT(4), .RAM_ADDR_WIDTH(8)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_busOverrideEn(ovEn),
        .i_busOverride(ov),
        .i_ctrlRegWr(regWr),
        .i_ctrlRegWrSel(regWrSel),
        .i_ctrlRegBusEn(regBusEn),
        .i_ctrlRegBusSel(regBusSel),
        .i_ctrlAluASel(aSel),
        .i_ctrlAluBWr(bWr),
        .i_ctrlAluOp(op),
        .i_ctrlAluShiftLeft(shl),
        .i_ctrlAluStart(start),
        .i_ctrlAluOE(aluOE),
        .i_ctrlRamAddressEn(marEn),
        .i_ctrlRamWriteEn(ramWe),
        .i_ctrlRamOE(ramOE),
        .o_bus(bus),
        .o_aluBusy(busy),
        .o_aluDone(done),
`ifdef DATAPATH_FLAGS_EN
        .o_aluFlags(flags),
`endif
        .o_busConflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] exp);
`ifdef DATAPATH_FLAGS_EN
        chk(tag, {30'd0, flags}, {30'd0, exp});
`else
        if (exp === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ovEn = 0; ov = 0; regWr = 0; regWrSel = 0; regBusEn = 0;
        regBusSel = 0; bWr = 0; start = 0; aluOE = 0;
        marEn = 0; ramWe = 0; ramOE = 0;
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [7:0] v);
        ovEn = 1; ov = v; regWr = 1; regWrSel = sel;
        tick();
        clr();
    endtask

    task automatic wr_b(input logic [7:0] v);
        ovEn = 1; ov = v; bWr = 1;
        tick();
        clr();
    endtask

    task automatic alu_start(input logic [1:0] a, input logic [1:0] o,
                             input logic left, input bit push, input logic [7:0] exp);
        aSel = a; op = o; shl = left; start = 1;
        if (push) q.push_back(exp);
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int n0, input int lat);
        int n;
        logic [7:0] e;
        n = n0;
        while (done !== 1'b1 && n < lat + 4) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, n, lat);
        e = (q.size() > 0) ? q.pop_front() : 8'hxx;
        aluOE = 1;
        #1;
        chk({tag, "_res"}, {24'd0, bus}, {24'd0, e});
        aluOE = 0;
    endtask

    initial begin
        clr();
        aSel = 0; op = 0; shl = 0;
        rst = 1;
        tick();
        tick();
        chk("rst_bus", {24'd0, bus}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_conf", {31'd0, conflict}, 32'd0);
        chk_flags("rst_flags", 2'b00);
        rst = 0;

        wr_reg(0, 8'h2A);
        regBusEn = 1; regBusSel = 0;
        #1;
        chk("r0_bus", {24'd0, bus}, 32'h2A);
        clr();
        chk("conf0", {31'd0, conflict}, 32'd0);

        wr_b(8'h01);
        alu_start(0, 2'b11, 0, 1, 8'h15);
        chk("shr1_busy", {31'd0, busy}, 32'd1);
        wait_done("shr1", 0, 1);
        chk("shr1_nbusy", {31'd0, busy}, 32'd0);
        aluOE = 1; regWr = 1; regWrSel = 1;
        tick();
        clr();
        regBusEn = 1; regBusSel = 1;
        #1;
        chk("r1_bus", {24'd0, bus}, 32'h15);
        clr();

        wr_reg(0, 8'h81);
        wr_b(8'h09);
        alu_start(0, 2'b11, 1, 1, 8'h00);
        tick();
        tick();
        tick();
        chk("shl9_busy", {31'd0, busy}, 32'd1);
        op = 2'b00; start = 1;
        tick();
        start = 0;
        chk("shl9_nodone", {31'd0, done}, 32'd0);
        wait_done("shl9", 4, 8);
        chk_flags("shl9_flags", 2'b11);
        tick();
        tick();
        chk("shl9_idle", {30'd0, busy, done}, 32'd0);

        wr_reg(0, 8'h2A);
        regBusEn = 1; regBusSel = 0; marEn = 1;
        tick();
        clr();
        regBusEn = 1; regBusSel = 1; ramWe = 1;
        tick();
        clr();
        ramOE = 1;
        #1;
        chk("ram_rd", {24'd0, bus}, 32'h15);
        chk("conf_pre", {31'd0, conflict}, 32'd0);
        ramWe = 1;
        tick();
        clr();
        chk("conf_rwoe", {31'd0, conflict}, 32'd1);
        ovEn = 1; ov = 8'h77; ramOE = 1; ramWe = 1;
        tick();
        clr();
        ramOE = 1;
        #1;
        chk("ram_keep", {24'd0, bus}, 32'h15);
        clr();
        tick();
        tick();
        chk("conf_sticky", {31'd0, conflict}, 32'd1);

        wr_reg(2, 8'hF0);
        wr_reg(3, 8'h10);
        regBusEn = 1; regBusSel = 3; bWr = 1;
        tick();
        clr();
        alu_start(2, 2'b00, 0, 1, 8'h00);
        chk("add_nbusy", {31'd0, busy}, 32'd0);
        wait_done("add", 0, 1);
        chk_flags("add_flags", 2'b11);
        regBusEn = 1; regBusSel = 2; bWr = 1;
        tick();
        clr();
        alu_start(3, 2'b01, 0, 1, 8'h20);
        wait_done("sub", 0, 1);
        chk_flags("sub_flags", 2'b10);
        alu_start(3, 2'b10, 0, 1, 8'h10);
        wait_done("and", 0, 1);
        chk_flags("and_flags", 2'b00);
        wr_b(8'h00);
        alu_start(3, 2'b11, 1, 1, 8'h10);
        chk("sh0_nbusy", {31'd0, busy}, 32'd0);
        wait_done("sh0", 0, 1);
        chk_flags("sh0_flags", 2'b00);
        chk("conf_still", {31'd0, conflict}, 32'd1);

        wr_b(8'h05);
        alu_start(0, 2'b11, 0, 0, 8'h00);
        tick();
        tick();
        chk("sh5_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        aluOE = 1;
        #1;
        chk("mid_res", {24'd0, bus}, 32'h0);
        aluOE = 0; regBusEn = 1; regBusSel = 0;
        #1;
        chk("mid_r0", {24'd0, bus}, 32'h0);
        chk("mid_conf", {31'd0, conflict}, 32'd0);
        clr();
        tick();
        rst = 0;
        wr_reg(1, 8'h03);
        wr_b(8'h04);
        alu_start(1, 2'b00, 0, 1, 8'h07);
        wait_done("add2", 0, 1);
        chk_flags("add2_flags", 2'b00);
        chk("q_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_param.md
Name: datapath_param

Overview:
Parametrised successor to the 8-bit CPU datapath. It keeps the same single shared bus and the same microcode-driven control style, generalised as follows:
- DATA_WIDTH-wide data path.
- REG_COUNT general registers.
- A sequential ALU with an iterative multi-bit shifter and a busy/done handshake.
- A RAM behind an address register.
- Registered bus-contention detection.
The block sits under the control unit and is driven one microstep per clock.

Parameters:
DATA_WIDTH, 8, width of bus, registers, ALU and RAM words (>=4)
REG_COUNT, 4, number of general registers (power of two, >=2)
RAM_ADDR_WIDTH, 8, RAM depth = 2**RAM_ADDR_WIDTH words (<=DATA_WIDTH)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  reset, asynchronous, active-high
i_busOverrideEn  in  1  drive i_busOverride onto bus
i_busOverride  in  DATA_WIDTH  external bus value (bench/loader)
i_ctrlRegWr  in  1  write bus into register i_ctrlRegWrSel
i_ctrlRegWrSel  in  $clog2(REG_COUNT)  destination register
i_ctrlRegBusEn  in  1  drive register i_ctrlRegBusSel onto bus
i_ctrlRegBusSel  in  $clog2(REG_COUNT)  source register
i_ctrlAluASel  in  $clog2(REG_COUNT)  ALU operand A register
i_ctrlAluBWr  in  1  load bus into ALU B register
i_ctrlAluOp  in  2  00 add, 01 sub, 10 and, 11 shift
i_ctrlAluShiftLeft  in  1  shift direction (1 = left)
i_ctrlAluStart  in  1  start ALU operation
i_ctrlAluOE  in  1  drive ALU result register onto bus
i_ctrlRamAddressEn  in  1  load bus[RAM_ADDR_WIDTH-1:0] into MAR
i_ctrlRamWriteEn  in  1  write bus into RAM[MAR]
i_ctrlRamOE  in  1  drive RAM[MAR] onto bus
o_bus  out  DATA_WIDTH  current bus value
o_aluBusy  out  1  ALU operation in progress
o_aluDone  out  1  one-cycle pulse, result register updated this edge
o_busConflict  out  1  sticky contention flag

Behaviour:
- Reset values: registers 0, B 0, ALU result 0, MAR 0, FSM IDLE, o_aluBusy 0, o_aluDone 0, o_busConflict 0. RAM contents are not reset.
- Bus source: combinational mux with priority override > RAM > ALU > register. o_bus is 0 when no source is enabled.
- Contention:
  - If two or more of {busOverrideEn, RamOE, AluOE, RegBusEn} are high at a rising edge, o_busConflict is set and stays set until reset.
  - RamWriteEn together with RamOE also sets the flag, and the RAM write is suppressed.
- Register write: reg[WrSel] <= bus on the edge. Reading and writing the same register in one cycle writes back the old value.
- ALU B register: loaded from bus when AluBWr is high.
- ALU FSM states: IDLE, SHIFT.
  - IDLE with Start, op != 11: A (reg[ASel]) and B are sampled; result is latched one edge later with o_aluDone=1; o_aluBusy stays 0. Result is add/sub modulo 2**DATA_WIDTH, or bitwise and.
  - IDLE with Start, op == 11: A is captured into the working register; count = min(B, DATA_WIDTH); go to SHIFT with o_aluBusy=1.
  - IDLE with Start and count 0: result = A, done pulses next edge, no SHIFT entry.
  - SHIFT: one logical bit shift per cycle, zero fill. When count reaches 0, the result register is loaded, o_aluDone pulses, o_aluBusy drops the same edge, and the FSM returns to IDLE.
  - Latency: count+1 edges from start to done. B >= DATA_WIDTH yields result 0 after DATA_WIDTH+1 edges.
- Start while busy: ignored. No restart, op inputs ignored.
- Result register: holds its value between completions. AluOE during busy drives the previous result.
- Reset mid-shift: returns to IDLE immediately; the partial result is discarded and the result register is 0.
- RAM: asynchronous read of RAM[MAR]; synchronous write. MAR and RAM may both load from the same bus value in one cycle; the write then uses the old MAR.

Optional Feature:
DATAPATH_FLAGS_EN:
- When defined, adds output o_aluFlags [1:0] = {carry, zero}, reset 00, updated only on o_aluDone edges.
  - carry: add carry-out, sub borrow (A<B), 0 for and; for shift, the last bit shifted out (0 if count 0).
  - zero: result == 0.
- When not defined, the port and its logic are absent and ALU behaviour is otherwise identical.

Test Plan:
- Reset, override 0x2A with RegWr sel 0, then RegBusEn sel 0 -> o_bus=0x2A; o_busConflict=0.
- r0=0x2A, B=0x01, op 11, right shift, Start -> o_aluBusy high 1 cycle, o_aluDone on 2nd edge, AluOE bus=0x15; write into r1 -> r1=0x15.
- r0=0x81, B=0x09 (>8), left shift -> done after 9 edges, result 0x00; with flags enabled, flags=2'b11. Start pulsed mid-shift is ignored.
- MAR<=r0 (0x2A); RamWriteEn with r1 on bus -> RamOE reads 0x15 at 0x2A. RamOE+RamWriteEn together -> RAM unchanged, conflict flag set and sticky.
- r2=0xF0, r3=0x10: add -> 0x00 (flags carry 1, zero 1); sub 0x10-0xF0 -> 0x20 with borrow 1; and -> 0x10.
- Reset asserted during 5-bit shift -> busy 0, result 0, registers 0 immediately. After release, a new add completes normally.
